store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 19 +
 rtl/store_data_align.sv | 30 +++
 rtl/store_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared memory-control definitions: store-kind encoding used by the byte-enable
// generator and the store buffer, plus the buffered-entry layout.
package store_buffer_pkg;

  typedef enum logic [2:0] {
    ST_SW  = 3'd0,
    ST_SH  = 3'd1,
    ST_SB  = 3'd2,
    ST_SWL = 3'd3,
    ST_SWR = 3'd4
  } st_kind_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_data_align.sv
// Moves register data onto the byte lanes a store writes; purely combinational.
module store_data_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]  be_ctrl,
  input  logic [1:0]  addr,
  input  logic [31:0] rt,
  output logic [31:0] aligned
);

  logic [4:0] w_shl;
  logic [4:0] w_shr;

  // 8*addr and 8*(3-addr); for a 2-bit value 3-addr equals ~addr.
  assign w_shl = {addr, 3'b000};
  assign w_shr = {~addr, 3'b000};

  always_comb begin
    aligned = rt;
    case (be_ctrl)
      ST_SW:   aligned = rt;
      ST_SH:   aligned = {rt[15:0], rt[15:0]};
      ST_SB:   aligned = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
      ST_SWL:  aligned = rt >> w_shr;
      ST_SWR:  aligned = rt << w_shl;
      default: aligned = rt;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: a circular FIFO of aligned stores draining to data
// memory, with a load/store word-address conflict check.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_be_ctrl,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_rt,
  output logic        st_stall,
  input  logic [31:0] ld_addr,
  input  logic        ld_valid,
  output logic        ld_conflict,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  sb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [31:0]   w_aligned;
  sb_entry_t     w_new;

  store_data_align u_align (
    .be_ctrl (st_be_ctrl),
    .addr    (st_addr[1:0]),
    .rt      (st_rt),
    .aligned (w_aligned)
  );

  // A full buffer refuses the store even when the head pops this same edge.
  assign w_full   = (r_count == FULL);
  assign w_push   = st_valid & ~w_full & ~reset;
  assign w_pop    = (r_count != '0) & mem_ack;
  assign st_stall = st_valid & w_full;

  assign w_new.waddr = st_addr[31:2];
  assign w_new.data  = w_aligned;
  assign w_new.be    = st_be;

  assign mem_req   = (r_count != '0);
  assign mem_addr  = r_mem[r_head].waddr;
  assign mem_wdata = r_mem[r_head].data;
  assign mem_be    = r_mem[r_head].be;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(AW'(i) - r_head)} < r_count) &&
          (r_mem[i].waddr == ld_addr[31:2]))
        w_hit = 1'b1;
    end
  end

  assign ld_conflict = ld_valid & (w_hit | (w_push & (st_addr[31:2] == ld_addr[31:2])));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
